// File: rtl/spi_cmd_pkg.sv
// Shared constants for the SPI command register file: opcodes, header layout,
// FSM state encoding and the saturating error-count helper.
package spi_cmd_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;

  localparam int unsigned OPC_MSB  = 15;
  localparam int unsigned OPC_LSB  = 12;
  localparam int unsigned LEN_MSB  = 11;
  localparam int unsigned LEN_LSB  = 8;
  localparam int unsigned ADDR_MSB = 7;
  localparam int unsigned ADDR_LSB = 0;

  localparam logic StIdle = 1'b0;
  localparam logic StData = 1'b1;

  localparam logic [7:0] ERR_MAX = 8'hFF;

  function automatic logic [7:0] err_inc(input logic [7:0] cnt);
    return (cnt == ERR_MAX) ? cnt : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/spi_cmd_watchdog.sv
// Inter-word watchdog: counts enabled cycles since the last clear and flags
// expiry for as long as the count sits at its limit.
module spi_cmd_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 48000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr || !en) begin
      cnt_q <= '0;
    end else if (cnt_q != LAST) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // High during the TIMEOUT_CYC-th idle cycle; a word landing that cycle still wins.
  assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/spi_cmd_regfile.sv
// Header/data command decoder writing a bank of 16-bit control registers from
// SPI words, with burst writes, single reads, burst watchdog and error count.
module spi_cmd_regfile
  import spi_cmd_pkg::*;
#(
  parameter int unsigned NREG        = 16,
  parameter int unsigned TIMEOUT_CYC = 48000,
  parameter logic [15:0] RD_INVALID  = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        word_in,
  input  logic               word_valid,
  output logic [NREG*16-1:0] reg_out,
  output logic               wr_strobe,
  output logic [7:0]         wr_addr,
  output logic [15:0]        rd_data,
  output logic               busy,
  output logic [7:0]         err_cnt
);

  logic [NREG-1:0][15:0] regs_q;
  logic                  state_q, state_d;
  logic [7:0]            cur_addr_q, cur_addr_d;
  logic [4:0]            rem_q, rem_d;
  logic [7:0]            err_q, err_d;
  logic [15:0]           rd_q, rd_d;
  logic                  wr_strobe_q, wr_strobe_d;
  logic [7:0]            wr_addr_q, wr_addr_d;
  logic                  wr_en;
  logic                  wd_expire;

  logic [3:0]  opc;
  logic [3:0]  hdr_len;
  logic [7:0]  hdr_addr;
  logic [15:0] rd_sel;
  logic        rd_hit;
  logic        wr_hit;

  assign opc      = word_in[OPC_MSB:OPC_LSB];
  assign hdr_len  = word_in[LEN_MSB:LEN_LSB];
  assign hdr_addr = word_in[ADDR_MSB:ADDR_LSB];

  spi_cmd_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (word_valid),
    .en     (state_q == StData),
    .expire (wd_expire)
  );

  // Address decode done by comparison so 8-bit addresses never index past NREG.
  always_comb begin
    rd_sel = RD_INVALID;
    rd_hit = 1'b0;
    wr_hit = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (hdr_addr == 8'(i)) begin
        rd_sel = regs_q[i];
        rd_hit = 1'b1;
      end
      if (cur_addr_q == 8'(i)) begin
        wr_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    rem_d       = rem_q;
    err_d       = err_q;
    rd_d        = rd_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_en       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (word_valid) begin
          case (opc)
            OP_NOP: ;
            OP_WRITE: begin
              cur_addr_d = hdr_addr;
              rem_d      = {1'b0, hdr_len} + 5'd1;
              state_d    = StData;
            end
            OP_READ: begin
              rd_d = rd_sel;
              if (!rd_hit) err_d = err_inc(err_q);
            end
            default: err_d = err_inc(err_q);
          endcase
        end
      end
      StData: begin
        if (word_valid) begin
          if (wr_hit) begin
            wr_en       = 1'b1;
            wr_strobe_d = 1'b1;
            wr_addr_d   = cur_addr_q;
          end else begin
            err_d = err_inc(err_q);
          end
          cur_addr_d = cur_addr_q + 8'd1;
          rem_d      = rem_q - 5'd1;
          if (rem_q == 5'd1) state_d = StIdle;
        end else if (wd_expire) begin
          state_d = StIdle;
          err_d   = err_inc(err_q);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      rem_q       <= '0;
      err_q       <= '0;
      rd_q        <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      rem_q       <= rem_d;
      err_q       <= err_d;
      rd_q        <= rd_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (cur_addr_q == 8'(i)) regs_q[i] <= word_in;
      end
    end
  end

  assign reg_out   = regs_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign rd_data   = rd_q;
  assign busy      = (state_q == StData);
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Self-checking bench for spi_cmd_regfile: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_spi_cmd_regfile;

  localparam int NREG = 16;
  localparam int TMO  = 20;

  logic               clk = 1'b0;
  logic               rst;
  logic [15:0]        word_in;
  logic               word_valid;
  logic [NREG*16-1:0] reg_out;
  logic               wr_strobe;
  logic [7:0]         wr_addr;
  logic [15:0]        rd_data;
  logic               busy;
  logic [7:0]         err_cnt;

  spi_cmd_regfile #(
    .NREG        (NREG),
    .TIMEOUT_CYC (TMO),
    .RD_INVALID  (16'hFFFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .word_in    (word_in),
    .word_valid (word_valid),
    .reg_out    (reg_out),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [15:0] m_reg [NREG];
  logic [15:0] m_rd;
  int          m_err;
  bit          m_burst;
  int          m_cur, m_rem, m_idle, m_wa;
  bit          m_strobe;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bump();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_reg[i] = 16'h0;
    m_rd = 16'h0; m_err = 0; m_burst = 0; m_cur = 0; m_rem = 0; m_idle = 0;
    m_wa = 0; m_strobe = 0;
  endtask

  task automatic model_step(input logic v, input logic [15:0] w);
    int a;
    m_strobe = 0;
    a = int'(w[7:0]);
    if (m_burst) begin
      if (v) begin
        if (m_cur < NREG) begin
          m_reg[m_cur] = w;
          m_strobe = 1;
          m_wa = m_cur;
        end else begin
          bump();
        end
        m_cur  = (m_cur + 1) % 256;
        m_rem  = m_rem - 1;
        m_idle = 0;
        if (m_rem == 0) m_burst = 0;
      end else begin
        m_idle++;
        if (m_idle >= TMO) begin
          m_burst = 0;
          bump();
        end
      end
    end else if (v) begin
      case (int'(w[15:12]))
        0: ;
        1: begin
          m_cur = a; m_rem = int'(w[11:8]) + 1; m_idle = 0; m_burst = 1;
        end
        2: begin
          if (a < NREG) m_rd = m_reg[a];
          else begin
            m_rd = 16'hFFFF;
            bump();
          end
        end
        default: bump();
      endcase
    end
  endtask

  task automatic model_compare(input string tag);
    logic [NREG*16-1:0] exp_bank;
    for (int i = 0; i < NREG; i++) exp_bank[16*i +: 16] = m_reg[i];
    chk({tag, " reg_out"}, 256'(reg_out), 256'(exp_bank));
    chk({tag, " rd_data"}, 256'(rd_data), 256'(m_rd));
    chk({tag, " err_cnt"}, 256'(err_cnt), 256'(m_err));
    chk({tag, " busy"}, 256'(busy), 256'(m_burst));
    chk({tag, " wr_strobe"}, 256'(wr_strobe), 256'(m_strobe));
    if (m_strobe) chk({tag, " wr_addr"}, 256'(wr_addr), 256'(m_wa));
  endtask

  task automatic cycle(input logic v, input logic [15:0] w, input string tag);
    word_in = w;
    word_valid = v;
    @(posedge clk);
    model_step(v, w);
    #1;
    model_compare(tag);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    word_valid = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    model_compare("reset");
  endtask

  function automatic logic [15:0] dut_reg(input int i);
    return reg_out[16*i +: 16];
  endfunction

  typedef struct {
    logic [15:0] w;
    logic        v;
    logic        busy;
    logic        st;
    logic [7:0]  wa;
    logic [7:0]  err;
    logic [15:0] rd;
    int          idx;
    logic [15:0] rv;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{16'h1005, 1'b1, 1'b1, 1'b0, 8'd0,  8'd0, 16'h0000, 5,  16'h0000};
    tbl[1] = '{16'hBEEF, 1'b1, 1'b0, 1'b1, 8'd5,  8'd0, 16'h0000, 5,  16'hBEEF};
    tbl[2] = '{16'h120E, 1'b1, 1'b1, 1'b0, 8'd5,  8'd0, 16'h0000, 14, 16'h0000};
    tbl[3] = '{16'h1111, 1'b1, 1'b1, 1'b1, 8'd14, 8'd0, 16'h0000, 14, 16'h1111};
    tbl[4] = '{16'h2222, 1'b1, 1'b1, 1'b1, 8'd15, 8'd0, 16'h0000, 15, 16'h2222};
    tbl[5] = '{16'h3333, 1'b1, 1'b0, 1'b0, 8'd15, 8'd1, 16'h0000, 0,  16'h0000};
    tbl[6] = '{16'h2005, 1'b1, 1'b0, 1'b0, 8'd15, 8'd1, 16'hBEEF, 5,  16'hBEEF};
    tbl[7] = '{16'h2020, 1'b1, 1'b0, 1'b0, 8'd15, 8'd2, 16'hFFFF, 5,  16'hBEEF};
    tbl[8] = '{16'h7000, 1'b1, 1'b0, 1'b0, 8'd15, 8'd3, 16'hFFFF, 5,  16'hBEEF};
    tbl[9] = '{16'h0000, 1'b0, 1'b0, 1'b0, 8'd15, 8'd3, 16'hFFFF, 14, 16'h1111};

    rst = 1'b1;
    word_in = 16'h0;
    word_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    apply_reset();

    // Directed table: single write, burst off the end, reads, bad opcode
    for (int i = 0; i < 10; i++) begin
      word_in = tbl[i].w;
      word_valid = tbl[i].v;
      @(posedge clk);
      model_step(tbl[i].v, tbl[i].w);
      #1;
      chk($sformatf("vec%0d busy", i), 256'(busy), 256'(tbl[i].busy));
      chk($sformatf("vec%0d wr_strobe", i), 256'(wr_strobe), 256'(tbl[i].st));
      chk($sformatf("vec%0d wr_addr", i), 256'(wr_addr), 256'(tbl[i].wa));
      chk($sformatf("vec%0d err_cnt", i), 256'(err_cnt), 256'(tbl[i].err));
      chk($sformatf("vec%0d rd_data", i), 256'(rd_data), 256'(tbl[i].rd));
      chk($sformatf("vec%0d reg", i), 256'(dut_reg(tbl[i].idx)), 256'(tbl[i].rv));
      model_compare($sformatf("vec%0d", i));
    end

    // Timeout: burst of 2 stalls after one word
    cycle(1'b1, 16'h1103, "tmo hdr");
    cycle(1'b1, 16'h0001, "tmo d0");
    for (int i = 0; i < TMO - 1; i++) cycle(1'b0, 16'h0, "tmo wait");
    chk("tmo busy before expiry", 256'(busy), 256'(1));
    cycle(1'b0, 16'h0, "tmo expire");
    chk("tmo busy after expiry", 256'(busy), 256'(0));
    chk("tmo err_cnt", 256'(err_cnt), 256'(4));
    chk("tmo reg3", 256'(dut_reg(3)), 256'(16'h0001));
    cycle(1'b1, 16'h0000, "tmo nop");
    chk("tmo reg4 untouched", 256'(dut_reg(4)), 256'(0));
    chk("tmo nop no strobe", 256'(wr_strobe), 256'(0));

    // Race: word arrives on the expiry cycle
    cycle(1'b1, 16'h1108, "race hdr");
    cycle(1'b1, 16'h0002, "race d0");
    for (int i = 0; i < TMO - 1; i++) cycle(1'b0, 16'h0, "race wait");
    cycle(1'b1, 16'h0003, "race d1");
    chk("race reg9", 256'(dut_reg(9)), 256'(16'h0003));
    chk("race err_cnt", 256'(err_cnt), 256'(4));
    chk("race busy", 256'(busy), 256'(0));

    // Address wrap 255 -> 0
    cycle(1'b1, 16'h11FF, "wrap hdr");
    cycle(1'b1, 16'h1234, "wrap d255");
    chk("wrap err_cnt", 256'(err_cnt), 256'(5));
    cycle(1'b1, 16'h5678, "wrap d0");
    chk("wrap reg0", 256'(dut_reg(0)), 256'(16'h5678));
    chk("wrap wr_addr", 256'(wr_addr), 256'(0));

    // Reset mid-burst
    cycle(1'b1, 16'h1F00, "rstb hdr");
    cycle(1'b1, 16'hAAAA, "rstb d0");
    cycle(1'b1, 16'hBBBB, "rstb d1");
    apply_reset();
    chk("rstb reg_out", 256'(reg_out), 256'(0));
    chk("rstb busy", 256'(busy), 256'(0));
    chk("rstb err_cnt", 256'(err_cnt), 256'(0));
    cycle(1'b1, 16'h1002, "rstb new hdr");
    cycle(1'b1, 16'h5555, "rstb new d0");
    chk("rstb reg2", 256'(dut_reg(2)), 256'(16'h5555));
    chk("rstb busy end", 256'(busy), 256'(0));

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      logic [15:0] w;
      logic        v;
      int          op;
      if ($urandom_range(0, 60) == 0) begin
        for (int k = 0; k < TMO + 2; k++) cycle(1'b0, 16'h0, "rand gap");
      end
      if ($urandom_range(0, 300) == 0) apply_reset();
      v = ($urandom_range(0, 3) != 0);
      if (m_burst) begin
        w = 16'($urandom);
      end else begin
        case ($urandom_range(0, 5))
          0: op = 0;
          1, 2: op = 1;
          3, 4: op = 2;
          default: op = int'($urandom_range(3, 15));
        endcase
        w = {4'(op), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 23))};
      end
      cycle(v, w, "rand");
    end

    // Error counter saturation
    apply_reset();
    for (int i = 0; i < 300; i++) cycle(1'b1, 16'hF000, "sat");
    chk("sat err_cnt", 256'(err_cnt), 256'(8'hFF));
    cycle(1'b1, 16'h2020, "sat read oob");
    chk("sat err_cnt hold", 256'(err_cnt), 256'(8'hFF));
    chk("sat rd_data", 256'(rd_data), 256'(16'hFFFF));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_cmd_regfile.md
Name: spi_cmd_regfile

Overview:
Sits directly downstream of the SPI slave shifter and consumes each received 16-bit word. It decodes a header/data command protocol and writes a bank of 16-bit control registers, with burst writes and single-register reads. It returns read data on a 16-bit word that the SPI stage loads into its MISO shift register on the next chip-select fall. A watchdog aborts incomplete bursts, and a saturating error counter records protocol faults.

Parameters:
NREG, 16, number of implemented registers (1..256); addresses 0..NREG-1 valid
TIMEOUT_CYC, 48000, clk cycles allowed between words of a burst (1 ms at 48 MHz)
RD_INVALID, 16'hFFFF, read-back value for an out-of-range address

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous, active-high reset
word_in  in  16  word from SPI stage (data16)
word_valid  in  1  one-cycle pulse: word_in updated (issued at CS rising edge)
reg_out  out  NREG*16  flattened register bank; reg i at [16*i+15:16*i]
wr_strobe  out  1  one-cycle pulse per register write
wr_addr  out  8  address of that write
rd_data  out  16  read-back word, feeds SPI stage MISO load (pin_state_in[15:0])
busy  out  1  high while in DATA state
err_cnt  out  8  saturating protocol-error count

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - all regs, rd_data, err_cnt = 0; wr_strobe = 0; wr_addr = 0; busy = 0; state = IDLE.
  - Applies mid-burst: burst abandoned, no further writes.
- Header word format: [15:12] opcode, [11:8] len-1 (1..16 data words), [7:0] start address.
- Opcodes: 0x0 NOP, 0x1 WRITE, 0x2 READ. Any other opcode is an error: err_cnt+1, state stays IDLE.
- State IDLE, on word_valid:
  - NOP: no action.
  - READ: rd_data <= reg[addr] at the next edge (latency 1). If addr >= NREG, rd_data <= RD_INVALID and err_cnt+1. len is ignored.
  - WRITE: load cur_addr = addr and remaining = len+1, clear the watchdog, go to DATA.
- State DATA, on word_valid (word treated as data regardless of content):
  - In-range cur_addr: reg[cur_addr] <= word_in.
  - Same edge: wr_strobe = 1 for one cycle, wr_addr = cur_addr.
  - The new reg value is visible on reg_out 1 cycle after word_valid.
  - cur_addr >= NREG: write dropped, no strobe, err_cnt+1.
  - cur_addr increments modulo 256 (8-bit wrap). Wrapping from 255 to 0 is legal.
  - remaining decrements; at 0 go to IDLE the same edge.
- Watchdog in DATA:
  - Counts clk cycles since the last accepted word.
  - On reaching TIMEOUT_CYC with no word_valid: go to IDLE, err_cnt+1.
  - word_valid in the same cycle as expiry: the word wins and is accepted as data; watchdog cleared.
- busy = (state == DATA), registered.
- err_cnt saturates at 8'hFF and never wraps.
- rd_data holds its value until the next READ or reset. Writes do not update rd_data, even to the same address.
- word_valid pulses are at least 16 SPI bit-times apart. Back-to-back pulses on consecutive clk cycles must still be handled, one word per cycle.

Decomposition:
- Package spi_cmd_pkg:
  - opcode constants OP_NOP/OP_WRITE/OP_READ
  - header field bit positions (OPC_MSB/LSB, LEN_MSB/LSB, ADDR_MSB/LSB)
  - state enum IDLE/DATA
  - ERR_MAX constant
- One sub-module, spi_cmd_watchdog: a clear/enable counter with TIMEOUT_CYC parameter and a one-cycle expire output.
- Register bank and FSM stay in the top module.

Test Plan:
- Single write: reset, then word 0x1005 followed by 0xBEEF -> reg[5] = 0xBEEF one cycle after the second pulse. wr_strobe pulses once with wr_addr = 5. busy high between the two words only. err_cnt = 0.
- Burst: 0x120E, then 0x1111, 0x2222, 0x3333 (NREG=16) -> reg[14] = 0x1111, reg[15] = 0x2222. Third word dropped (addr 16 out of range), err_cnt = 1, exactly 2 strobes, IDLE afterwards.
- Read: after the single-write test, send 0x2005 -> rd_data = 0xBEEF next cycle. Then 0x2020 -> rd_data = 0xFFFF, err_cnt +1. Then 0x7000 -> err_cnt +1, no register changes.
- Timeout: 0x1103, 0x0001, then no word for TIMEOUT_CYC cycles -> reg[3] = 0x0001, returns to IDLE, err_cnt +1. A following 0x0000 is treated as NOP (no write to reg[4]).
- Timeout race: word_valid asserted exactly on the expiry cycle -> word written, no error increment.
- Reset mid-burst: 0x1F00, two data words, then rst for 1 cycle -> all regs 0, busy 0, err_cnt 0. The next word is decoded as a header.
- Saturation: 300 invalid-opcode headers -> err_cnt = 0xFF.
